mem_access_unit: RTL and testbench

Load/store sequencer between the CPU memory stage and the 1 KB byte-addressed data memory. It accepts one memory operation at a time and always drives the data memory with word-aligned word accesses. Stores narrower than a word become read-modify-write sequences. Loads narrower than a word are extracted and sign- or zero-extended here, so the data memory's byte-load flag is tied inactive. Byte order is little-endian: byte k of a word occupies bits [8k+7:8k].

---
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit.sv | 83 ++++++++
 tb/tb_mem_access_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: CPU-side request/response and data-memory bus of the load/store sequencer.
interface mem_access_unit_if #(parameter int ADDR_W = 12);
  logic              req;
  logic [2:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_din;
  logic              dm_we;
  logic              dm_lb_flag;
  logic [31:0]       dm_dout;
  modport master (output req, op, addr, wdata, dm_dout,
                  input ready, done, err, rdata, dm_addr, dm_din, dm_we, dm_lb_flag);
  modport slave (input req, op, addr, wdata, dm_dout,
                 output ready, done, err, rdata, dm_addr, dm_din, dm_we, dm_lb_flag);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences byte/half/word loads and stores onto a word-only data memory.
module mem_access_unit #(parameter int ADDR_W = 12) (
  input logic            clk,
  input logic            rst_n,
  mem_access_unit_if.slave bus
);
  localparam logic [2:0] OP_LW = 3'd0, OP_LB = 3'd1, OP_LBU = 3'd2, OP_LH = 3'd3,
                         OP_LHU = 3'd4, OP_SW = 3'd5, OP_SB = 3'd6, OP_SH = 3'd7;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP} state_t;
  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d, merge_q, merge_d;
  logic              err_q, err_d;
  logic              mis;
  logic [4:0]        lane_sh;
  logic [31:0]       sh, ext, lane_m;
  assign mis = ((bus.op == OP_LW || bus.op == OP_SW) && bus.addr[1:0] != 2'b00) ||
               ((bus.op == OP_LH || bus.op == OP_LHU || bus.op == OP_SH) && bus.addr[0]);
  assign lane_sh = {addr_q[1:0], 3'b000};
  // Halves are 2-byte aligned, so the byte-offset shift also selects the half.
  assign sh = bus.dm_dout >> lane_sh;
  assign ext = op_q == OP_LB  ? {{24{sh[7]}}, sh[7:0]} :
               op_q == OP_LBU ? {24'b0, sh[7:0]} :
               op_q == OP_LH  ? {{16{sh[15]}}, sh[15:0]} :
               op_q == OP_LHU ? {16'b0, sh[15:0]} : sh;
  assign lane_m = (op_q == OP_SB ? 32'h0000_00ff : 32'h0000_ffff) << lane_sh;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.req) begin
        op_d    = bus.op;
        addr_d  = bus.addr;
        wdata_d = bus.wdata;
        err_d   = mis;
        state_d = mis ? RESP : bus.op <= OP_LHU ? LOAD : bus.op == OP_SW ? WRITE : RMW_RD;
      end
      LOAD: begin
        rdata_d = ext;
        state_d = RESP;
      end
      RMW_RD: begin
        merge_d = (bus.dm_dout & ~lane_m) | ((wdata_q << lane_sh) & lane_m);
        state_d = RMW_WR;
      end
      WRITE, RMW_WR: state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  assign bus.ready      = state_q == IDLE;
  assign bus.done       = state_q == RESP;
  assign bus.err        = state_q == RESP && err_q;
  assign bus.rdata      = rdata_q;
  assign bus.dm_addr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.dm_we      = state_q == WRITE || state_q == RMW_WR;
  assign bus.dm_din     = state_q == WRITE ? wdata_q : state_q == RMW_WR ? merge_q : 32'h0;
  assign bus.dm_lb_flag = 1'b0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized load/store checks against a byte-array reference model.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [256];
  logic [7:0]  rb [1024];
  logic [31:0] ref_rdata = 32'h0;
  mem_access_unit_if #(.ADDR_W(12)) bus ();
  mem_access_unit #(.ADDR_W(12)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.dm_dout = mem[bus.dm_addr[9:2]];
  always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr[9:2]] <= bus.dm_din;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] word_at(input int b);
    return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
  endfunction
  task automatic model(input logic [2:0] o, input logic [11:0] a, input logic [31:0] wd,
                       output int lat, output logic e, output int pulses, output logic [31:0] din);
    int i, b;
    logic [15:0] h;
    i = int'(a[9:0]);
    b = i - int'(a[1:0]);
    e = ((o == 0 || o == 5) && a[1:0] != 2'b00) || ((o == 3 || o == 4 || o == 7) && a[0]);
    lat = e ? 1 : (o == 6 || o == 7) ? 3 : 2;
    pulses = (!e && o >= 5) ? 1 : 0;
    h = {rb[(i + 1) % 1024], rb[i]};
    if (!e)
      case (o)
        3'd0: ref_rdata = word_at(b);
        3'd1: ref_rdata = {{24{rb[i][7]}}, rb[i]};
        3'd2: ref_rdata = {24'h0, rb[i]};
        3'd3: ref_rdata = {{16{h[15]}}, h};
        3'd4: ref_rdata = {16'h0, h};
        3'd5: for (int k = 0; k < 4; k++) rb[b + k] = wd[8*k +: 8];
        3'd6: rb[i] = wd[7:0];
        default: begin rb[i] = wd[7:0]; rb[i + 1] = wd[15:8]; end
      endcase
    din = word_at(b);
  endtask
  task automatic run_op(input logic [2:0] o, input logic [11:0] a, input logic [31:0] wd, input bit hold);
    int lat, pulses, got, seen, n;
    logic e;
    logic [31:0] din;
    n = 0;
    while (!bus.ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_wait", 32'(bus.ready), 32'h1);
    model(o, a, wd, lat, e, pulses, din);
    bus.req = 1'b1; bus.op = o; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.req = hold;
    got = 0;
    seen = 0;
    for (int c = 1; c <= 8 && got == 0; c++) begin
      bus.op = 3'($urandom); bus.addr = 12'($urandom); bus.wdata = $urandom;
      @(negedge clk);
      if (bus.dm_we) begin
        seen++;
        chk("dm_din", bus.dm_din, din);
        chk("dm_addr", 32'(bus.dm_addr), 32'({a[11:2], 2'b00}));
      end else chk("dm_din_idle", bus.dm_din, 32'h0);
      if (bus.done) begin
        got = c;
        chk("err", 32'(bus.err), 32'(e));
        chk("rdata", bus.rdata, ref_rdata);
      end
    end
    chk("latency", 32'(got), 32'(lat));
    chk("we_pulses", 32'(seen), 32'(pulses));
  endtask
  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int k = 0; k < 4; k++) rb[4*i + k] = w[8*k +: 8];
    end
    bus.req = 1'b0; bus.op = 3'd0; bus.addr = 12'h0; bus.wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'h1);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_we", 32'(bus.dm_we), 32'h0);
    chk("rst_addr", 32'(bus.dm_addr), 32'h0);
    chk("rst_din", bus.dm_din, 32'h0);
    chk("rst_lbflag", 32'(bus.dm_lb_flag), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd5, 12'h010, 32'hDEADBEEF, 0);
    run_op(3'd0, 12'h010, 32'h0, 0);
    chk("lw_value", ref_rdata, 32'hDEADBEEF);
    run_op(3'd1, 12'h013, 32'h0, 0);
    chk("lb_value", ref_rdata, 32'hFFFFFFDE);
    run_op(3'd2, 12'h013, 32'h0, 0);
    run_op(3'd3, 12'h012, 32'h0, 0);
    chk("lh_value", ref_rdata, 32'hFFFFDEAD);
    run_op(3'd4, 12'h010, 32'h0, 0);
    run_op(3'd6, 12'h011, 32'h12345677, 0);
    run_op(3'd0, 12'h010, 32'h0, 0);
    chk("sb_value", ref_rdata, 32'hDEAD77EF);
    run_op(3'd7, 12'h012, 32'h0000A5A5, 0);
    run_op(3'd0, 12'h010, 32'h0, 0);
    chk("sh_value", ref_rdata, 32'hA5A577EF);
    run_op(3'd0, 12'h011, 32'h0, 0);
    run_op(3'd7, 12'h013, 32'h1234, 0);
    run_op(3'd5, 12'h012, 32'h5555AAAA, 0);
    run_op(3'd5, 12'h020, 32'h11223344, 0);
    @(negedge clk);
    bus.req = 1'b1; bus.op = 3'd6; bus.addr = 12'h020; bus.wdata = 32'h99;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    rst_n = 1'b0;
    ref_rdata = 32'h0;
    #1;
    chk("midrst_ready", 32'(bus.ready), 32'h1);
    chk("midrst_done", 32'(bus.done), 32'h0);
    chk("midrst_we", 32'(bus.dm_we), 32'h0);
    chk("midrst_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    chk("midrst_we2", 32'(bus.dm_we), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'd0, 12'h020, 32'h0, 0);
    chk("midrst_mem", ref_rdata, 32'h11223344);
    for (int t = 0; t < 200; t++)
      run_op(3'($urandom), 12'($urandom), $urandom, t >= 100);
    bus.req = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
